// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencer: FSM state encoding and
// the bundle of per-stage enable/bubble/flush controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN      = 2'd0,
    PC_MUL_WAIT = 2'd1,
    PC_HALT     = 2'd2
  } pipe_ctrl_state_t;

  localparam int MUL_CNT_W = 4;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
    logic ex_mem_bubble;
    logic mem_wb_en;
  } stage_ctrl_t;

  // Uniform control word: every enable set to en, every bubble/flush set to bub.
  function automatic stage_ctrl_t ctrl_fill(input logic en, input logic bub);
    stage_ctrl_t c;
    c.pc_en         = en;
    c.pc_redirect   = 1'b0;
    c.if_id_en      = en;
    c.if_id_flush   = bub;
    c.id_ex_en      = en;
    c.id_ex_bubble  = bub;
    c.ex_mem_en     = en;
    c.ex_mem_bubble = bub;
    c.mem_wb_en     = en;
    return c;
  endfunction

  // MUL occupying EX: hold the front end, push a noop into EX/MEM, let older work drain.
  function automatic stage_ctrl_t ctrl_mul_stall();
    stage_ctrl_t c;
    c               = ctrl_fill(1'b0, 1'b0);
    c.ex_mem_en     = 1'b1;
    c.ex_mem_bubble = 1'b1;
    c.mem_wb_en     = 1'b1;
    return c;
  endfunction

  function automatic stage_ctrl_t ctrl_branch();
    stage_ctrl_t c;
    c              = ctrl_fill(1'b1, 1'b0);
    c.pc_redirect  = 1'b1;
    c.if_id_flush  = 1'b1;
    c.id_ex_bubble = 1'b1;
    return c;
  endfunction

  function automatic stage_ctrl_t ctrl_load_use();
    stage_ctrl_t c;
    c              = ctrl_fill(1'b1, 1'b0);
    c.pc_en        = 1'b0;
    c.if_id_en     = 1'b0;
    c.id_ex_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Three free-running performance counters with individual enables; they wrap
// silently and clear on the synchronous active-low reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cycle_inc,
  input  logic             retire_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (cycle_inc)  cycle_cnt  <= cycle_cnt  + CNT_W'(1);
      if (retire_inc) retire_cnt <= retire_cnt + CNT_W'(1);
      if (stall_inc)  stall_cnt  <= stall_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline: arbitrates halt, MUL occupancy,
// EX redirect and load-use stall into per-stage enable/bubble/flush controls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall_req,
  input  logic             ex_mul_valid,
  input  logic             ex_take_branch,
  input  logic             mem_wb_valid_inst,
  input  logic             mem_wb_halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_en,
  output logic             ex_mem_bubble,
  output logic             mem_wb_en,
  output logic             halted,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam bit                   MUL_STALLS = (MUL_LAT > 1);
  localparam logic [MUL_CNT_W-1:0] MUL_RELOAD = MUL_STALLS ? MUL_CNT_W'(MUL_LAT - 2) : '0;

  pipe_ctrl_state_t     state, state_nxt;
  logic [MUL_CNT_W-1:0] mul_cnt, mul_cnt_nxt;
  stage_ctrl_t          ctrl;
  logic                 halt_event;
  logic                 halt_take;

  assign halt_event = mem_wb_valid_inst & mem_wb_halt;
  assign halt_take  = halt_event & (state != PC_HALT);

  // Per-cycle decode; priority is halt > mul > branch > load-use.
  always_comb begin
    ctrl        = ctrl_fill(1'b1, 1'b0);
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    unique case (state)
      PC_RUN: begin
        if (halt_event) begin
          ctrl        = ctrl_fill(1'b0, 1'b0);
          state_nxt   = PC_HALT;
          mul_cnt_nxt = '0;
        end else if (ex_mul_valid && MUL_STALLS) begin
          ctrl        = ctrl_mul_stall();
          state_nxt   = PC_MUL_WAIT;
          mul_cnt_nxt = MUL_RELOAD;
        end else if (ex_take_branch) begin
          ctrl = ctrl_branch();
        end else if (id_stall_req) begin
          ctrl = ctrl_load_use();
        end
      end
      PC_MUL_WAIT: begin
        if (halt_event) begin
          ctrl        = ctrl_fill(1'b0, 1'b0);
          state_nxt   = PC_HALT;
          mul_cnt_nxt = '0;
        end else if (mul_cnt != '0) begin
          ctrl        = ctrl_mul_stall();
          mul_cnt_nxt = mul_cnt - MUL_CNT_W'(1);
        end else begin
          state_nxt = PC_RUN;
        end
      end
      PC_HALT: begin
        ctrl = ctrl_fill(1'b0, 1'b0);
      end
      default: begin
        ctrl        = ctrl_fill(1'b0, 1'b0);
        state_nxt   = PC_RUN;
        mul_cnt_nxt = '0;
      end
    endcase
    if (!rst) begin
      ctrl = ctrl_fill(1'b0, 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= PC_RUN;
      mul_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  assign pc_en         = ctrl.pc_en;
  assign pc_redirect   = ctrl.pc_redirect;
  assign if_id_en      = ctrl.if_id_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_en      = ctrl.id_ex_en;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_en     = ctrl.ex_mem_en;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign halted        = rst & (state == PC_HALT);
  assign ctrl_state    = state;

  // The halting instruction still retires even though its cycle freezes MEM/WB.
  logic cycle_inc, retire_inc, stall_inc;
  assign cycle_inc  = rst & (state != PC_HALT);
  assign retire_inc = rst & mem_wb_valid_inst & (ctrl.mem_wb_en | halt_take);
  assign stall_inc  = rst & ~ctrl.pc_en & ~halted;

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .cycle_inc  (cycle_inc),
    .retire_inc (retire_inc),
    .stall_inc  (stall_inc),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
  );

endmodule
